// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_responder_pkg;

    localparam int WORD_W      = 16;
    localparam int DMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, write-first, registered read port, no reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];

    // rdata_o only moves on an access so the response word holds between accesses
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_o       <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency handshaked data-memory target for the MEM stage; stalls the pipe until the access completes.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        stall
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                rdata_vld_q;

    logic                accept;
    logic                access;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [WORD_W-1:0]   ram_wdata;
    logic [WORD_W-1:0]   ram_rdata;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[WORD_W-1:ADDR_W];

    assign accept = (state_q == IDLE) && req_valid;

    // With single-cycle latency the access happens on the accepting edge, so the
    // RAM is fed straight from the request rather than from the capture registers.
    assign access    = (LATENCY == 1) ? accept : ((state_q == BUSY) && (cnt_q == 4'd1));
    assign ram_we    = access && ((LATENCY == 1) ? req_we : we_q);
    assign ram_addr  = (LATENCY == 1) ? req_addr[ADDR_W-1:0] : addr_q;
    assign ram_wdata = (LATENCY == 1) ? req_wdata : wdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
            end
            if (access) begin
                rdata_vld_q <= 1'b1;
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .en_i    (access),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // The RAM read register has no reset, so mask it until the first access lands.
    assign resp_rdata = rdata_vld_q ? ram_rdata : '0;
    assign stall      = req_valid & ~resp_valid;

endmodule
